// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider. Each channel produces a registered divided clock and a
// one-cycle enable; new divisors are staged in a shadow register and applied only at period boundaries.
module clk_div_prog #(
  parameter int NCH     = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NCH-1:0]                        EN,
  input  logic                                  DIV_LD,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] DIV_CH,
  input  logic [DIV_W-1:0]                      DIV_VAL,
  output logic [NCH-1:0]                        PEND,
  output logic [NCH-1:0]                        CLKOUT,
  output logic [NCH-1:0]                        CE
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W:0]    NCH_V   = (CH_W + 1)'(NCH);
  localparam logic [DIV_W-1:0] ONE     = {{(DIV_W - 1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

  logic             ch_ok;
  logic [DIV_W-1:0] div_in;

  // Out-of-range channel selects are dropped; divisors below 2 are clamped to 2.
  assign ch_ok  = ({1'b0, DIV_CH} < NCH_V);
  assign div_in = (DIV_VAL < TWO) ? TWO : DIV_VAL;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W:0]   half;
    logic             pend_r;
    logic             clk_r;
    logic             ce_r;
    logic             wr;
    logic             wrap;
    logic             apply;

    assign wr      = DIV_LD && ch_ok && (DIV_CH == CH_W'(i));
    assign wrap    = EN[i] && (cnt == div_act - ONE);
    assign apply   = (wrap || !EN[i]) && pend_r;
    assign cnt_inc = cnt + ONE;
    assign half    = ({1'b0, div_act} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

    // Outputs are registered from the next counter value so they line up with the cycle of that count.
    // At a wrap or while disabled the next count is 0, where CLKOUT and CE are 0 for any legal divisor.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt     <= '0;
        div_act <= DEF_VAL;
        div_shd <= DEF_VAL;
        pend_r  <= 1'b0;
        clk_r   <= 1'b0;
        ce_r    <= 1'b0;
      end else begin
        if (apply)
          div_act <= div_shd;
        if (wr)
          div_shd <= div_in;
        pend_r <= wr || (pend_r && !apply);
        if (!EN[i] || wrap) begin
          cnt   <= '0;
          clk_r <= 1'b0;
          ce_r  <= 1'b0;
        end else begin
          cnt   <= cnt_inc;
          clk_r <= ({1'b0, cnt_inc} >= half);
          ce_r  <= (cnt_inc == div_act - ONE);
        end
      end
    end

    assign PEND[i]   = pend_r;
    assign CLKOUT[i] = clk_r;
    assign CE[i]     = ce_r;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed plus randomised bench for clk_div_prog: a cycle model predicts {PEND,CLKOUT,CE} into a
// scoreboard queue as each stimulus cycle is driven, and the entry is popped and checked after the edge.
module tb_clk_div_prog;
  localparam int NCH     = 3;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;
  localparam int CH_W    = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NCH-1:0]   EN;
  logic             DIV_LD;
  logic [CH_W-1:0]  DIV_CH;
  logic [DIV_W-1:0] DIV_VAL;
  logic [NCH-1:0]   PEND;
  logic [NCH-1:0]   CLKOUT;
  logic [NCH-1:0]   CE;

  int  m_cnt [NCH];
  int  m_d   [NCH];
  int  m_shd [NCH];
  bit  m_pend[NCH];
  logic [3*NCH-1:0] sb_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  bit  reached;

  clk_div_prog #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIV_LD(DIV_LD), .DIV_CH(DIV_CH),
    .DIV_VAL(DIV_VAL), .PEND(PEND), .CLKOUT(CLKOUT), .CE(CE)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_d[i] = DEF_DIV; m_shd[i] = DEF_DIV; m_pend[i] = 1'b0;
    end
  endtask

  // Behaviour at one rising edge, using the inputs currently driven.
  task automatic model_step();
    bit wrap, app;
    for (int i = 0; i < NCH; i++) begin
      wrap = EN[i] && (m_cnt[i] == m_d[i] - 1);
      app  = (wrap || !EN[i]) && m_pend[i];
      if (!EN[i] || wrap) m_cnt[i] = 0;
      else m_cnt[i] = m_cnt[i] + 1;
      if (app) begin m_d[i] = m_shd[i]; m_pend[i] = 1'b0; end
      if (DIV_LD && int'(DIV_CH) == i) begin
        m_shd[i]  = (int'(DIV_VAL) < 2) ? 2 : int'(DIV_VAL);
        m_pend[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [3*NCH-1:0] model_out();
    logic [NCH-1:0] p, c, e;
    for (int i = 0; i < NCH; i++) begin
      p[i] = m_pend[i];
      c[i] = (m_cnt[i] >= (m_d[i] + 1) / 2);
      e[i] = (m_cnt[i] == m_d[i] - 1);
    end
    return {p, c, e};
  endfunction

  task automatic check_output(input string tag, input logic [3*NCH-1:0] obs, input logic [3*NCH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed {PEND,CLKOUT,CE}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [3*NCH-1:0] exp;
    model_step();
    sb_q.push_back(model_out());
    @(posedge CLK);
    #1;
    exp = sb_q.pop_front();
    check_output(tag, {PEND, CLKOUT, CE}, exp);
  endtask

  task automatic apply_stimulus(input string tag, input logic [NCH-1:0] en, input logic ld,
                                input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] val, input int n);
    EN = en; DIV_LD = ld; DIV_CH = ch; DIV_VAL = val;
    for (int k = 0; k < n; k++) tick(tag);
    DIV_LD = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = '0; DIV_LD = 1'b0; DIV_CH = '0; DIV_VAL = '0;
    model_reset();
    #3;
    check_output("reset_state", {PEND, CLKOUT, CE}, '0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // Default divide-by-4 on ch0 only; other channels stay idle.
    apply_stimulus("t1_div4", 3'b001, 1'b0, 2'd0, 8'd0, 12);

    apply_stimulus("t2_load5", 3'b001, 1'b1, 2'd0, 8'd5, 1);
    apply_stimulus("t2_div5", 3'b001, 1'b0, 2'd0, 8'd0, 16);

    // Back to 4, then retarget to 6 mid-period.
    apply_stimulus("t3_load4", 3'b001, 1'b1, 2'd0, 8'd4, 1);
    apply_stimulus("t3_run4", 3'b001, 1'b0, 2'd0, 8'd0, 12);
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      if (m_cnt[0] == 0 && m_d[0] == 4) reached = 1'b1;
      else tick("t3_seek");
    end
    check_output("t3_seek_reached", {8'd0, reached}, 9'd1);
    apply_stimulus("t3_load6", 3'b001, 1'b1, 2'd0, 8'd6, 1);
    apply_stimulus("t3_div6", 3'b001, 1'b0, 2'd0, 8'd0, 18);

    // Clamping, last-write-wins, and out-of-range channel ignored.
    apply_stimulus("t4_load0", 3'b011, 1'b1, 2'd0, 8'd0, 1);
    apply_stimulus("t4_load1", 3'b011, 1'b1, 2'd0, 8'd1, 1);
    apply_stimulus("t4_ch1", 3'b011, 1'b1, 2'd1, 8'd1, 1);
    apply_stimulus("t4_badch", 3'b011, 1'b1, 2'd3, 8'd7, 1);
    apply_stimulus("t4_div2", 3'b011, 1'b0, 2'd0, 8'd0, 12);

    // Load landing exactly on a ch2 wrap edge.
    apply_stimulus("tw_load3", 3'b111, 1'b1, 2'd2, 8'd3, 1);
    apply_stimulus("tw_run", 3'b111, 1'b0, 2'd0, 8'd0, 8);
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      if (m_cnt[2] == m_d[2] - 1) reached = 1'b1;
      else tick("tw_seek");
    end
    check_output("tw_seek_reached", {8'd0, reached}, 9'd1);
    apply_stimulus("tw_load_on_wrap", 3'b111, 1'b1, 2'd2, 8'd5, 1);
    apply_stimulus("tw_after", 3'b111, 1'b0, 2'd0, 8'd0, 14);

    // EN dropped at cnt=2 on ch2 (period 5) for 3 cycles.
    reached = 1'b0;
    for (int k = 0; k < 12 && !reached; k++) begin
      if (m_cnt[2] == 2) reached = 1'b1;
      else tick("t5_seek");
    end
    check_output("t5_seek_reached", {8'd0, reached}, 9'd1);
    apply_stimulus("t5_en_low", 3'b011, 1'b0, 2'd0, 8'd0, 3);
    apply_stimulus("t5_en_high", 3'b111, 1'b0, 2'd0, 8'd0, 10);

    // Async reset during a high phase with a load pending.
    apply_stimulus("t6_load9", 3'b001, 1'b1, 2'd0, 8'd9, 1);
    EN = 3'b001; DIV_LD = 1'b1; DIV_CH = 2'd0; DIV_VAL = 8'd9;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (m_pend[0] && m_cnt[0] >= (m_d[0] + 1) / 2) reached = 1'b1;
      else tick("t6_seek");
    end
    DIV_LD = 1'b0;
    check_output("t6_seek_reached", {8'd0, reached}, 9'd1);
    RST = 1'b1;
    #1;
    check_output("t6_async_reset", {PEND, CLKOUT, CE}, '0);
    model_reset();
    @(posedge CLK); #1;
    check_output("t6_reset_held", {PEND, CLKOUT, CE}, '0);
    RST = 1'b0;
    apply_stimulus("t6_def_div", 3'b111, 1'b0, 2'd0, 8'd0, 10);

    // Randomised enables and loads.
    for (int k = 0; k < 80; k++) begin
      EN      = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
      DIV_LD  = ($urandom_range(0, 5) == 0);
      DIV_CH  = CH_W'($urandom_range(0, 3));
      DIV_VAL = DIV_W'($urandom_range(0, 9));
      tick("rand");
    end
    DIV_LD = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
